snake_pixel_render: RTL and testbench

- Pixel-stream renderer directly downstream of the VGA timing generator; consumes its hs/vs/valid stream and produces 12-bit RGB for the snake playfield.
- Divides the 640x480 active area into a 32x24 grid of 20x20-pixel cells.
- Fetches each cell's 2-bit tile code from the game map RAM, which has a synchronous read port, and maps it to a colour.
- Realigns hs/vs to the 2-cycle pixel pipeline and emits a frame tick so game logic can update the map during vertical blanking.

---
 rtl/snake_pkg.sv | 25 ++
 rtl/snake_pixel_render_if.sv | 26 ++
 rtl/snake_cell_counter.sv | 72 +++++++
 rtl/snake_pixel_render.sv | 98 +++++++++
 tb/tb_snake_pixel_render.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake playfield: grid geometry, tile codes and colours.
// Also used by the game-logic block that writes the map RAM.
package snake_pkg;

   localparam int CELL   = 20;
   localparam int COLS   = 32;
   localparam int ROWS   = 24;
   localparam int ADDR_W = 10;

   typedef enum logic [1:0] {
      TILE_EMPTY = 2'd0,
      TILE_BODY  = 2'd1,
      TILE_HEAD  = 2'd2,
      TILE_FOOD  = 2'd3
   } tile_e;

   typedef logic [11:0] rgb_t;

   localparam rgb_t C_EMPTY = 12'h000;
   localparam rgb_t C_BODY  = 12'h0F0;
   localparam rgb_t C_HEAD  = 12'hFF0;
   localparam rgb_t C_FOOD  = 12'hF00;
   localparam rgb_t C_GRID  = 12'h222;

endpackage

// File: rtl/snake_pixel_render_if.sv
// Pixel-stream bundle around the renderer: timing-generator input, map RAM read port, video out.
interface snake_pixel_render_if #(
   parameter int AW = snake_pkg::ADDR_W
);

   logic          hs_in;
   logic          vs_in;
   logic          valid_in;
   logic [AW-1:0] map_addr;
   logic [1:0]    map_data;
   logic          hs;
   logic          vs;
   logic [11:0]   rgb;
   logic          frame_tick;

   modport master (
      input  hs_in, vs_in, valid_in, map_data,
      output map_addr, hs, vs, rgb, frame_tick
   );

   modport slave (
      output hs_in, vs_in, valid_in, map_data,
      input  map_addr, hs, vs, rgb, frame_tick
   );

endinterface

// File: rtl/snake_cell_counter.sv
// Tracks the current pixel's position in the cell grid and flags the first
// pixel column / first line of each cell for grid drawing.
module snake_cell_counter #(
   parameter int CELL = snake_pkg::CELL,
   parameter int COLS = snake_pkg::COLS,
   parameter int ROWS = snake_pkg::ROWS,
   localparam int PX_W  = $clog2(CELL),
   localparam int COL_W = $clog2(COLS),
   localparam int ROW_W = $clog2(ROWS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic             vs_in,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic             cell_edge
);

   localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(CELL - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   logic [PX_W-1:0] px_cnt;
   logic [PX_W-1:0] ln_cnt;
   logic            valid_q;
   logic            eol;

   assign eol = valid_q & ~valid_in;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
   // reset is asynchronous so the counters clear even without a running pixel clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         px_cnt <= '0;
         col    <= '0;
      end else if (!valid_in) begin
         px_cnt <= '0;
         col    <= '0;
      end else if (px_cnt == PX_LAST) begin
         px_cnt <= '0;
         if (col != COL_LAST) col <= col + 1'b1;
      end else begin
         px_cnt <= px_cnt + 1'b1;
      end
   end

   // Vertical sync wins over an end-of-line falling in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         ln_cnt  <= '0;
         row     <= '0;
      end else begin
         valid_q <= valid_in;
         if (!vs_in) begin
            ln_cnt <= '0;
            row    <= '0;
         end else if (eol) begin
            if (ln_cnt == PX_LAST) begin
               ln_cnt <= '0;
               if (row != ROW_LAST) row <= row + 1'b1;
            end else begin
               ln_cnt <= ln_cnt + 1'b1;
            end
         end
      end
   end

   assign cell_edge = (px_cnt == '0) || (ln_cnt == '0);

endmodule

// File: rtl/snake_pixel_render.sv
// Two-stage pixel renderer: map address from the cell counters, colour lookup on the
// returned tile code, sync realigned to the pipeline, frame tick at vsync start.
module snake_pixel_render
   import snake_pkg::tile_e, snake_pkg::rgb_t,
          snake_pkg::TILE_EMPTY, snake_pkg::TILE_BODY, snake_pkg::TILE_HEAD, snake_pkg::TILE_FOOD;
#(
   parameter int   CELL    = snake_pkg::CELL,
   parameter int   COLS    = snake_pkg::COLS,
   parameter int   ROWS    = snake_pkg::ROWS,
   parameter int   ADDR_W  = snake_pkg::ADDR_W,
   parameter bit   GRID_EN = 1'b1,
   parameter rgb_t C_EMPTY = snake_pkg::C_EMPTY,
   parameter rgb_t C_BODY  = snake_pkg::C_BODY,
   parameter rgb_t C_HEAD  = snake_pkg::C_HEAD,
   parameter rgb_t C_FOOD  = snake_pkg::C_FOOD,
   parameter rgb_t C_GRID  = snake_pkg::C_GRID
) (
   input logic                 clk,
   input logic                 reset,
   snake_pixel_render_if.master bus
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);

   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic             cell_edge;

   logic v1, hs1, vs1, e1;
   logic vs_prev;
   rgb_t colour;

   snake_cell_counter #(
      .CELL (CELL),
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_counter (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (bus.valid_in),
      .vs_in     (bus.vs_in),
      .row       (row),
      .col       (col),
      .cell_edge (cell_edge)
   );

   // Constant power-of-two COLS reduces the multiply to a {row,col} concatenation.
   assign bus.map_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

   // Stage 1: the map RAM read is in flight, so carry the per-pixel side info alongside it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1  <= 1'b0;
         hs1 <= 1'b1;
         vs1 <= 1'b1;
         e1  <= 1'b0;
      end else begin
         v1  <= bus.valid_in;
         hs1 <= bus.hs_in;
         vs1 <= bus.vs_in;
         e1  <= cell_edge;
      end
   end

   // NOTE: every branch of a combinational block must assign its outputs; the default
   // written first guarantees that and so prevents latch inference.
   always_comb begin
      colour = '0;
      if (v1) begin
         case (tile_e'(bus.map_data))
            TILE_EMPTY: colour = (GRID_EN && e1) ? C_GRID : C_EMPTY;
            TILE_BODY:  colour = C_BODY;
            TILE_HEAD:  colour = C_HEAD;
            TILE_FOOD:  colour = C_FOOD;
            default:    colour = '0;
         endcase
      end
   end

   // vs_prev clears to 0 so a reset released inside vsync does not fake a falling edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.rgb        <= '0;
         bus.hs         <= 1'b1;
         bus.vs         <= 1'b1;
         bus.frame_tick <= 1'b0;
         vs_prev        <= 1'b0;
      end else begin
         bus.rgb        <= colour;
         bus.hs         <= hs1;
         bus.vs         <= vs1;
         bus.frame_tick <= vs_prev & ~bus.vs_in;
         vs_prev        <= bus.vs_in;
      end
   end

endmodule

// File: tb/tb_snake_pixel_render.sv
// Directed bench for snake_pixel_render: RAM model, scoreboard of expected video out,
// independent frame-tick model.
module tb_snake_pixel_render;
   import snake_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #20 clk = ~clk;

   snake_pixel_render_if #(.AW(ADDR_W)) bus ();

   snake_pixel_render dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   logic [1:0] mem [1024];

   always @(posedge clk) bus.map_data <= mem[bus.map_addr];

   typedef struct {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   logic p1 = 1'b0;   // vs_in driven one step ago
   logic p2 = 1'b0;   // vs_in driven two steps ago

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_addr(input int ln, input int x);
      int r, c;
      r = (ln / 20 > 23) ? 23 : ln / 20;
      c = (x / 20 > 31) ? 31 : x / 20;
      return r * 32 + c;
   endfunction

   function automatic logic [11:0] exp_colour(input int addr, input bit on_edge);
      case (mem[addr])
         2'd0:    return on_edge ? 12'h222 : 12'h000;
         2'd1:    return 12'h0F0;
         2'd2:    return 12'hFF0;
         default: return 12'hF00;
      endcase
   endfunction

   // One pixel clock: score outputs due from two steps ago, then drive this step's inputs.
   task automatic step(input logic v, input logic h, input logic vsi,
                       input int ln, input int x, input bit chk_addr);
      exp_t e;
      exp_t o;
      @(negedge clk);
      if (q.size() == 2) begin
         o = q.pop_front();
         check("rgb", 32'(bus.rgb), 32'(o.rgb));
         check("hs",  32'(bus.hs),  32'(o.hs));
         check("vs",  32'(bus.vs),  32'(o.vs));
      end
      check("frame_tick", 32'(bus.frame_tick), 32'(p2 & ~p1));
      bus.valid_in = v;
      bus.hs_in    = h;
      bus.vs_in    = vsi;
      p2 = p1;
      p1 = vsi;
      #1;
      if (chk_addr) check("map_addr", 32'(bus.map_addr), 32'(exp_addr(ln, x)));
      e.rgb = v ? exp_colour(exp_addr(ln, x), (x % 20 == 0) || (ln % 20 == 0)) : 12'h000;
      e.hs  = h;
      e.vs  = vsi;
      q.push_back(e);
   endtask

   task automatic line(input int ln, input int npix);
      for (int x = 0; x < npix; x++) step(1'b1, 1'b1, 1'b1, ln, x, 1'b1);
      for (int b = 0; b < 20; b++) step(1'b0, !(b >= 4 && b < 12), 1'b1, ln, 0, 1'b0);
   endtask

   task automatic do_reset(input logic vs_rel);
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      for (int i = 0; i < 5; i++) begin
         bus.valid_in = 1'($urandom);
         bus.hs_in    = 1'($urandom);
         bus.vs_in    = 1'($urandom);
         #1;
         check("rst_rgb",  32'(bus.rgb),        32'h0);
         check("rst_hs",   32'(bus.hs),         32'h1);
         check("rst_vs",   32'(bus.vs),         32'h1);
         check("rst_tick", 32'(bus.frame_tick), 32'h0);
         check("rst_addr", 32'(bus.map_addr),   32'h0);
         @(negedge clk);
      end
      bus.valid_in = 1'b0;
      bus.hs_in    = 1'b1;
      bus.vs_in    = vs_rel;
      reset        = 1'b1;
      p2 = 1'b0;
      p1 = vs_rel;
   endtask

   initial begin
      for (int a = 0; a < 1024; a++)
         mem[a] = (a % 5 == 1) ? 2'd1 : (a % 11 == 4) ? 2'd3 : 2'd0;
      mem[33] = 2'd2;
      mem[34] = 2'd0;
      bus.valid_in = 1'b0;
      bus.hs_in    = 1'b1;
      bus.vs_in    = 1'b1;
      reset        = 1'b0;

      do_reset(1'b1);
      repeat (4) step(1'b0, 1'b1, 1'b1, 0, 0, 1'b1);

      // Row 0 with an over-long first line, then rows down to line 20 (row 1).
      line(0, 660);
      for (int l = 1; l < 20; l++) line(l, 640);
      line(20, 80);

      // Short vsync returns addressing to row 0.
      step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
      repeat (3) step(1'b0, 1'b1, 1'b1, 0, 0, 1'b1);
      line(0, 40);

      // Long vsync: exactly one tick at its start.
      repeat (1600) step(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
      repeat (3) step(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);

      // Reset during vsync clears the pending tick and must not produce another.
      repeat (2) step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      do_reset(1'b0);
      repeat (5) step(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
      repeat (3) step(1'b0, 1'b1, 1'b1, 0, 0, 1'b1);
      line(0, 30);
      repeat (4) step(1'b0, 1'b1, 1'b1, 0, 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
